// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and FSM state encoding for the serial adder family
package adder_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: 1-bit combinational full adder
// Ports: a, b, ci -> inputs; s = a^b^ci; co = majority(a, b, ci)
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/fa_serial.sv
// fa_serial: bit-serial ripple adder, one full-adder cell, LSB first
// Ports: clk, rst (sync, active-high); start/a/b/ci request and operands;
//        s/co registered result; busy while running; done one-cycle completion pulse
module fa_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [CW-1:0]    cnt;
    logic             c, sb, cb, last;

    fa_bit u_cell (.a(a_sh[0]), .b(b_sh[0]), .ci(c), .s(sb), .co(cb));

    // Sum bits enter from the MSB side; written as shifts so WIDTH=1 needs no slice.
    assign sum_nx = (sum_sh >> 1) | (WIDTH'(sb) << (WIDTH - 1));
    assign last   = cnt == CW'(WIDTH - 1);

    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE)
                                      : (last ? ST_IDLE : ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            co     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    a_sh <= a;
                    b_sh <= b;
                    c    <= ci;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
            end else begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                c      <= cb;
                sum_sh <= sum_nx;
                if (last) begin
                    s    <= sum_nx;
                    co   <= cb;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fa_serial.sv
// tb_fa_serial: directed and exhaustive checks of fa_serial at WIDTH=4 and WIDTH=1
module tb_fa_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, ci, co, busy, done;
    logic [3:0] a, b, s;
    logic       start1, ci1, co1, busy1, done1;
    logic [0:0] a1, b1, s1;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] m_s;
    logic       m_co;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    fa_serial #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .s(s), .co(co), .busy(busy), .done(done)
    );

    fa_serial #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .s(s1), .co(co1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Full transaction on the WIDTH=4 instance; operands are scrambled while running.
    task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vci,
                        input logic [3:0] es, input logic eco);
        int lat;
        a = va; b = vb; ci = vci; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            check("busy_run", busy, 1);
            check("s_hold", s, m_s);
            check("co_hold", co, m_co);
            a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            tick();
            lat++;
        end
        check("latency4", lat, 4);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", s, es);
        check("cout", co, eco);
        m_s = es; m_co = eco;
        tick();
        check("done_fall", done, 0);
    endtask

    initial begin
        vecs[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
        vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
        vecs[5] = '{4'h6, 4'h7, 1'b0, 4'hD, 1'b0};

        // reset with start held high
        rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'hF; ci = 1'b1;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        tick(); tick();
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0; start = 1'b0;
        m_s = 4'h0; m_co = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end

        for (int i = 0; i < 6; i++)
            run4(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

        // start during RUN is ignored
        a = 4'h2; b = 4'h2; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'h7; b = 4'h7; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", busy, 1);
        tick();
        check("ign_done_early", done, 0);
        tick();
        check("ign_done", done, 1);
        check("ign_s", s, 4'h4);
        check("ign_co", co, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ign_no_second_done", done, 0);
            check("ign_idle", busy, 0);
        end

        // back-to-back: restart in the done cycle
        a = 4'h9; b = 4'h9; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("b2b_s1_hold", s, 4'h4);
        tick();
        check("b2b_done1", done, 1);
        check("b2b_gap", busy, 0);
        check("b2b_s1", s, 4'h2);
        check("b2b_co1", co, 1);
        a = 4'h1; b = 4'h1; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done1_fall", done, 0);
        check("b2b_busy2", busy, 1);
        tick(); tick(); tick();
        check("b2b_busy_hold", busy, 1);
        check("b2b_s_hold", s, 4'h2);
        check("b2b_co_hold", co, 1);
        tick();
        check("b2b_done2", done, 1);
        check("b2b_s2", s, 4'h2);
        check("b2b_co2", co, 0);
        tick();

        // abort with reset mid-operation
        a = 4'hF; b = 4'hF; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_s", s, 0);
        check("abort_co", co, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        m_s = 4'h0; m_co = 1'b0;

        // exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            logic [4:0] r;
            r = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            run4(i[3:0], i[7:4], i[8], r[3:0], r[4]);
        end

        // exhaustive WIDTH=1
        for (int i = 0; i < 8; i++) begin
            int lat;
            logic [1:0] r;
            r = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
            a1 = i[0]; b1 = i[1]; ci1 = i[2]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 10) begin
                check("w1_busy", busy1, 1);
                tick();
                lat++;
            end
            check("w1_latency", lat, 1);
            check("w1_sum", {co1, s1}, r);
            tick();
            check("w1_done_fall", done1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fa_serial.md
Name: fa_serial

Overview:
- Bit-serial ripple adder. Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Reuses a single full-adder cell, trading area for latency against the parallel multi-bit adders.
- Sits upstream of result consumers that accept a start/done handshake.
- Serves as the first clocked arithmetic block in the adder family.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request an add; sampled only while idle.
- a  input  WIDTH  operand a; captured on an accepted start.
- b  input  WIDTH  operand b; captured on an accepted start.
- ci  input  1  carry in; captured on an accepted start.
- s  output  WIDTH  registered sum; holds the last result.
- co  output  1  registered carry out; holds the last result.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle pulse when s and co update.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: when rst is sampled high at an edge:
  - state becomes IDLE; s=0, co=0, busy=0, done=0.
  - shift registers, carry register and bit counter are cleared.
  - rst has priority over start.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge k:
  - capture a and b into shift registers a_sh and b_sh, and ci into carry register c.
  - cnt=0, state becomes RUN, busy=1 from edge k.
- IDLE, start=0: hold all state; s and co keep their previous result.
- RUN, each edge:
  - the full-adder cell combines a_sh[0], b_sh[0] and c into sum bit sb and carry bit cb.
  - sb shifts into the sum shift register from the MSB side; a_sh and b_sh shift right by one.
  - c becomes cb and cnt increments.
- RUN, edge where cnt==WIDTH-1 (this is edge k+WIDTH):
  - s takes the complete sum, including the final bit; co takes the final cb.
  - done=1, busy=0, state becomes IDLE.
- done is high exactly for the one cycle after edge k+WIDTH, then returns to 0.
- Latency: result is visible WIDTH cycles after the start edge. For WIDTH=1 that is the next edge.
- Arithmetic: {co,s} equals a+b+ci computed at WIDTH+1 bits. Overflow appears only in co.
- Boundary conditions:
  - start while in RUN is ignored: no queueing, no restart.
  - a, b and ci changes during RUN have no effect.
  - start high in the done cycle (state IDLE) is accepted. done falls and busy rises at that edge, so busy is low for exactly one cycle between back-to-back operations.
  - s and co never change while busy=1; they change only at the completion edge or on reset.
  - rst asserted mid-operation aborts the add: no done pulse, s=0, co=0.
  - cnt is $clog2(WIDTH) bits wide, minimum 1 bit, and never wraps past WIDTH-1.

Decomposition:
- Shared package (adder_pkg) holds:
  - state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1.
  - the default WIDTH constant, 4.
- One sub-module: fa_bit, a 1-bit combinational full adder (s = a^b^ci; co = majority of a, b, ci), instantiated once as the serial cell.
- FSM, counter and shift registers live in fa_serial.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 -> s=4'h0, co=0, busy=0, done=0. No operation starts after rst falls until start is sampled high again.
2. Basic add: a=4'h3, b=4'h5, ci=0, start at edge k -> busy=1 during edges k..k+3. After edge k+4: done=1 for one cycle, s=4'h8, co=0.
3. Carry cases:
   - a=4'hF, b=4'h1, ci=0 -> s=4'h0, co=1.
   - a=4'hF, b=4'hF, ci=1 -> s=4'hF, co=1.
   - a=4'h0, b=4'h0, ci=1 -> s=4'h1, co=0.
4. Ignored start: start a=4'h2, b=4'h2. At edge k+2 pulse start with a=4'h7, b=4'h7 -> result s=4'h4, co=0 at k+4, exactly one done pulse. The second request is lost.
5. Back-to-back and abort:
   - Start a=4'h9, b=4'h9, ci=0; assert start again in the done cycle with a=4'h1, b=4'h1 -> first result s=4'h2, co=1. Second result s=4'h2, co=0 four cycles later; busy low for exactly one cycle between.
   - Separately, assert rst at edge k+2 -> no done pulse, s=0, co=0.
6. Exhaustive check, WIDTH=4 and WIDTH=1: all a, b, ci combinations -> {co,s} matches the a+b+ci reference model, and done occurs exactly WIDTH cycles after each start.
